// File: rtl/prog_loader_8085.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_8085
// Purpose  : Byte-stream program loader for the single-cycle 8085-style
//            processor. Receives a frame  LEN, N program bytes, CSUM  over a
//            valid/ready byte interface, writes the program bytes into
//            instruction memory and checks the checksum. On a good checksum
//            it pulses pc_clr and releases the processor from hold.
//            This block is the writer side of instruction memory.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W     instruction memory address width (depth 2**ADDR_W)
//   BASE_ADDR  first instruction memory address written
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse, begins a load from IDLE, DONE or ERR
//   byte_in     incoming frame byte
//   byte_valid  byte_in holds a valid byte this cycle
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction memory write enable (one cycle per byte)
//   imem_addr   instruction memory write address
//   imem_wdata  instruction memory write data
//   cpu_hold    1 = processor clock-enable gated off
//   pc_clr      one-cycle pulse that zeroes the processor PC
//   load_done   load finished with good checksum (held until next start)
//   load_err    length or checksum error (held until next start)
// ============================================================================
module prog_loader_8085 #(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_hold,
    output logic              pc_clr,
    output logic              load_done,
    output logic              load_err
);

    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_len;
    logic [7:0]        w_len_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [7:0]        r_sum;
    logic [7:0]        w_sum_nxt;

    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        r_wdata;
    logic [7:0]        w_wdata_nxt;
    logic              r_pc_clr;
    logic              w_pc_clr_nxt;

    logic              w_xfer;
    logic              w_len_bad;
    logic [7:0]        w_sum_add;
    logic [7:0]        w_cnt_inc;
    logic [ADDR_W-1:0] w_wr_addr;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    assign byte_ready = (r_state == S_LEN) || (r_state == S_DATA) ||
                        (r_state == S_CSUM);
    assign w_xfer     = byte_valid && byte_ready;

    // A frame may be exactly as long as the memory, never longer, never empty.
    assign w_len_bad  = (byte_in == 8'd0) ||
                        ({24'd0, byte_in} > 32'(c_DEPTH));

    assign w_sum_add  = r_sum + byte_in;
    assign w_cnt_inc  = r_cnt + 8'd1;

    // Address arithmetic is done wide, then truncated so that a non-zero base
    // wraps modulo the memory depth.
    assign w_wr_addr  = ADDR_W'(BASE_ADDR + int'(r_cnt));

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_sum_nxt    = r_sum;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_pc_clr_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LEN;
                    w_cnt_nxt   = 8'd0;
                    w_sum_nxt   = 8'd0;
                end
            end

            S_LEN: begin
                if (w_xfer) begin
                    if (w_len_bad) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_len_nxt   = byte_in;
                        w_cnt_nxt   = 8'd0;
                        w_sum_nxt   = 8'd0;
                    end
                end
            end

            S_DATA: begin
                if (w_xfer) begin
                    w_sum_nxt   = w_sum_add;
                    w_cnt_nxt   = w_cnt_inc;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_wr_addr;
                    w_wdata_nxt = byte_in;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (w_xfer) begin
                    if (byte_in == r_sum) begin
                        w_state_nxt  = S_DONE;
                        w_pc_clr_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_ERR;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops any write still pending from the previous
    // cycle; memory contents themselves are untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= 8'd0;
            r_cnt    <= 8'd0;
            r_sum    <= 8'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 8'd0;
            r_pc_clr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sum    <= w_sum_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_pc_clr <= w_pc_clr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The processor is released only while DONE; DONE is entered on
    // the same edge that raises pc_clr, so the two line up.
    // ------------------------------------------------------------------------
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign pc_clr     = r_pc_clr;
    assign cpu_hold   = (r_state != S_DONE);
    assign load_done  = (r_state == S_DONE);
    assign load_err   = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_8085.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader_8085
// Purpose  : Self-checking bench for prog_loader_8085. A frame-level model
//            predicts every output each cycle; directed frames pin the model
//            with literal expectations, then randomized frames follow.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader_8085;

    localparam int BASE  = 0;
    localparam int DEPTH = 32;

    // model modes
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       imem_we;
    logic [4:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_hold;
    logic       pc_clr;
    logic       load_done;
    logic       load_err;

    prog_loader_8085 #(.ADDR_W(5), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .pc_clr     (pc_clr),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Frame-level model: mode plus position within the current frame.
    // Position 0 is the LEN byte, 1..N program bytes, N+1 the checksum.
    // ------------------------------------------------------------------------
    int         m_mode = M_IDLE;
    int         m_pos  = 0;
    int         m_n    = 0;
    logic [7:0] m_sum  = 8'd0;
    logic       e_we   = 1'b0;
    logic [4:0] e_addr = 5'd0;
    logic [7:0] e_wdata = 8'd0;
    logic       e_pc   = 1'b0;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        m_live = 1'b1;
        e_we   = 1'b0;
        e_pc   = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_pos  = 0;
            m_sum  = 8'd0;
        end else if (m_mode != M_BUSY) begin
            if (start) begin
                m_mode = M_BUSY;
                m_pos  = 0;
                m_sum  = 8'd0;
            end
        end else if (byte_valid) begin
            if (m_pos == 0) begin
                if (byte_in == 8'd0 || int'(byte_in) > DEPTH) begin
                    m_mode = M_ERR;
                end else begin
                    m_n   = int'(byte_in);
                    m_pos = 1;
                    m_sum = 8'd0;
                end
            end else if (m_pos <= m_n) begin
                m_sum   = m_sum + byte_in;
                e_we    = 1'b1;
                e_addr  = 5'((BASE + m_pos - 1) % DEPTH);
                e_wdata = byte_in;
                m_pos++;
            end else begin
                if (byte_in == m_sum) begin
                    m_mode = M_DONE;
                    e_pc   = 1'b1;
                end else begin
                    m_mode = M_ERR;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare and write monitor, away from the active edge.
    // ------------------------------------------------------------------------
    logic [7:0] dmem [DEPTH];
    int         n_wr = 0;
    int         n_pc = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_mode == M_BUSY));
            chk("cpu_hold",   32'(cpu_hold),   32'(m_mode != M_DONE));
            chk("load_done",  32'(load_done),  32'(m_mode == M_DONE));
            chk("load_err",   32'(load_err),   32'(m_mode == M_ERR));
            chk("pc_clr",     32'(pc_clr),     32'(e_pc));
            chk("imem_we",    32'(imem_we),    32'(e_we));
            if (e_we) begin
                chk("imem_addr",  32'(imem_addr),  32'(e_addr));
                chk("imem_wdata", 32'(imem_wdata), 32'(e_wdata));
            end
        end
        if (imem_we) begin
            dmem[imem_addr] = imem_wdata;
            n_wr++;
        end
        if (pc_clr) n_pc++;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    logic [7:0] fq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit st);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        start      = st;
        tick();
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic send_fq(input int gap);
        foreach (fq[i]) send(fq[i], gap, 1'b0);
    endtask

    int w0;
    int p0;
    logic [7:0] s;

    initial begin
        for (int i = 0; i < DEPTH; i++) dmem[i] = 8'd0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_addr",  32'(imem_addr),  32'h0);
        chk("rst_wdata", 32'(imem_wdata), 32'h0);
        chk("rst_hold",  32'(cpu_hold),   32'h1);
        chk("rst_ready", 32'(byte_ready), 32'h0);
        rst = 1'b0;
        tick();

        // ---------------- 1: good load, back-to-back ----------------
        w0 = n_wr; p0 = n_pc;
        do_start();
        fq = '{8'h03, 8'h3E, 8'h05, 8'h80, 8'hC3};
        send_fq(0);
        tick(); tick();
        chk("t1_writes", n_wr - w0, 3);
        chk("t1_pcclr",  n_pc - p0, 1);
        chk("t1_mem0",   32'(dmem[0]), 32'h3E);
        chk("t1_mem1",   32'(dmem[1]), 32'h05);
        chk("t1_mem2",   32'(dmem[2]), 32'h80);
        chk("t1_done",   32'(load_done), 32'h1);
        chk("t1_err",    32'(load_err),  32'h0);
        chk("t1_hold",   32'(cpu_hold),  32'h0);

        // ---------------- 2: bad checksum ----------------
        w0 = n_wr; p0 = n_pc;
        do_start();
        fq = '{8'h03, 8'h3E, 8'h05, 8'h80, 8'hC4};
        send_fq(0);
        tick(); tick();
        chk("t2_writes", n_wr - w0, 3);
        chk("t2_pcclr",  n_pc - p0, 0);
        chk("t2_err",    32'(load_err), 32'h1);
        chk("t2_hold",   32'(cpu_hold), 32'h1);

        // ---------------- 3: length errors ----------------
        w0 = n_wr;
        do_start();
        send(8'h00, 0, 1'b0);
        tick();
        chk("t3a_writes", n_wr - w0, 0);
        chk("t3a_err",    32'(load_err), 32'h1);

        w0 = n_wr;
        do_start();
        send(8'h21, 0, 1'b0);
        tick();
        chk("t3b_writes", n_wr - w0, 0);
        chk("t3b_err",    32'(load_err), 32'h1);

        w0 = n_wr;
        do_start();
        send(8'h20, 0, 1'b0);
        s = 8'd0;
        for (int i = 0; i < 32; i++) begin
            send(8'(i) ^ 8'hA5, 0, 1'b0);
            s = s + (8'(i) ^ 8'hA5);
        end
        tick();
        chk("t3c_writes", n_wr - w0, 32);
        chk("t3c_in_csum", 32'(byte_ready), 32'h1);
        chk("t3c_mem0",   32'(dmem[0]),  32'hA5);
        chk("t3c_mem31",  32'(dmem[31]), 32'hBA);
        send(s, 0, 1'b0);
        tick();
        chk("t3c_done",   32'(load_done), 32'h1);

        // ---------------- 4: gapped valid, wrapping sum ----------------
        w0 = n_wr;
        do_start();
        fq = '{8'h02, 8'hFF, 8'h02, 8'h01};
        send_fq(3);
        tick();
        chk("t4_writes", n_wr - w0, 2);
        chk("t4_mem0",   32'(dmem[0]), 32'hFF);
        chk("t4_mem1",   32'(dmem[1]), 32'h02);
        chk("t4_done",   32'(load_done), 32'h1);

        // ---------------- 5: reset mid-DATA ----------------
        do_start();
        fq = '{8'h04, 8'h11, 8'h22};
        send_fq(0);
        rst = 1'b1;
        tick();
        chk("t5_ready", 32'(byte_ready), 32'h0);
        chk("t5_we",    32'(imem_we),    32'h0);
        chk("t5_addr",  32'(imem_addr),  32'h0);
        chk("t5_wdata", 32'(imem_wdata), 32'h0);
        chk("t5_hold",  32'(cpu_hold),   32'h1);
        chk("t5_pcclr", 32'(pc_clr),     32'h0);
        chk("t5_done",  32'(load_done),  32'h0);
        chk("t5_err",   32'(load_err),   32'h0);
        rst = 1'b0;
        tick();
        do_start();
        fq = '{8'h02, 8'hA1, 8'hB2, 8'h53};
        send_fq(0);
        tick();
        chk("t5_mem0", 32'(dmem[0]), 32'hA1);
        chk("t5_mem1", 32'(dmem[1]), 32'hB2);
        chk("t5_done2", 32'(load_done), 32'h1);

        // ---------------- 6: reload, start ignored mid-frame ----------------
        do_start();
        chk("t6_done_clr", 32'(load_done), 32'h0);
        chk("t6_hold_up",  32'(cpu_hold),  32'h1);
        w0 = n_wr;
        send(8'h03, 0, 1'b0);
        send(8'h10, 0, 1'b0);
        send(8'h20, 0, 1'b1);
        send(8'h30, 1, 1'b0);
        send(8'h60, 0, 1'b0);
        tick();
        chk("t6_writes", n_wr - w0, 3);
        chk("t6_mem2",   32'(dmem[2]), 32'h30);
        chk("t6_done",   32'(load_done), 32'h1);

        // ---------------- randomized frames ----------------
        for (int f = 0; f < 60; f++) begin
            int  kind;
            int  n;
            bit  aborted;
            // stray bytes while not accepting
            if ($urandom_range(0, 3) == 0) send(8'($urandom), 0, 1'b0);
            do_start();
            kind = $urandom_range(0, 19);
            if (kind == 0)      n = 0;
            else if (kind == 1) n = $urandom_range(33, 255);
            else                n = $urandom_range(1, 32);
            send(8'(n), $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
            aborted = 1'b0;
            s = 8'd0;
            if (n >= 1 && n <= 32) begin
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    s = s + b;
                    send(b, $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
                    if ($urandom_range(0, 199) == 0) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    if ($urandom_range(0, 3) == 0) s = s + 8'(1 + $urandom_range(0, 254));
                    send(s, $urandom_range(0, 2), 1'b0);
                end
            end
            repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
